// File: rtl/jt12_mixer_if.sv
// jt12_mixer_if -- bundle of all non-clock/reset signals of the stereo mixer.
//
// Signals (driven by master, i.e. the sound core / bench, unless noted):
//   cen        clock enable for the mixing datapath
//   sample     start strobe, sampled when cen=1
//   ch_l/ch_r  NCH packed signed inputs, channel k at [k*WIN +: WIN]
//   mute       per-channel mute, captured together with the inputs
//   gain_wr    one-clk gain write strobe (not cen-qualified)
//   gain_addr  channel whose gain is written
//   gain_din   new gain, unsigned, 4 fractional bits (16 = unity)
//   left/right mixed signed outputs                  (driven by slave)
//   out_valid  one-clk pulse when left/right update  (driven by slave)
//   sat_l/sat_r clip flags of the last update        (driven by slave)
//   busy       a mixing pass is in progress          (driven by slave)
//   ovr        one-clk pulse for a dropped strobe    (driven by slave)
interface jt12_mixer_if #(
   parameter int NCH   = 4,
   parameter int WIN   = 16,
   parameter int WOUT  = 16,
   parameter int WGAIN = 8
);
   localparam int WA = (NCH > 1) ? $clog2(NCH) : 1;

   logic                    cen;
   logic                    sample;
   logic [NCH*WIN-1:0]      ch_l;
   logic [NCH*WIN-1:0]      ch_r;
   logic [NCH-1:0]          mute;
   logic                    gain_wr;
   logic [WA-1:0]           gain_addr;
   logic [WGAIN-1:0]        gain_din;
   logic signed [WOUT-1:0]  left;
   logic signed [WOUT-1:0]  right;
   logic                    out_valid;
   logic                    sat_l;
   logic                    sat_r;
   logic                    busy;
   logic                    ovr;

   modport master (
      output cen, sample, ch_l, ch_r, mute, gain_wr, gain_addr, gain_din,
      input  left, right, out_valid, sat_l, sat_r, busy, ovr
   );

   modport slave (
      input  cen, sample, ch_l, ch_r, mute, gain_wr, gain_addr, gain_din,
      output left, right, out_valid, sat_l, sat_r, busy, ovr
   );
endinterface

// File: rtl/jt12_mixer.sv
// jt12_mixer -- parametrised stereo mixer with per-channel gain and mute.
//
// A sample strobe captures all channel inputs, mute bits and a snapshot of
// the gain table. One multiplier per side then walks the channels, one per
// cen cycle, into a wide accumulator. A final cen cycle drops the 4 gain
// fraction bits, saturates to WOUT and registers the result.
//
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset (acts regardless of cen)
//   mix    jt12_mixer_if.slave: cen, sample, ch_l, ch_r, mute, gain_wr,
//          gain_addr, gain_din in; left, right, out_valid, sat_l, sat_r,
//          busy, ovr out
module jt12_mixer #(
   parameter int NCH   = 4,
   parameter int WIN   = 16,
   parameter int WOUT  = 16,
   parameter int WGAIN = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   jt12_mixer_if.slave   mix
);
   localparam int WA   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int WP   = WIN + WGAIN + 1;        // signed x unsigned product
   localparam int WACC = WIN + WGAIN + WA + 1;   // NCH products cannot overflow this

   localparam logic [WGAIN-1:0]        GAIN_UNITY = WGAIN'(32'd16);
   localparam logic signed [WACC-1:0]  OUT_MAX = {{(WACC-WOUT+1){1'b0}}, {(WOUT-1){1'b1}}};
   localparam logic signed [WACC-1:0]  OUT_MIN = {{(WACC-WOUT+1){1'b1}}, {(WOUT-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t                   state_r, state_s;
   logic                     capture_s, acc_en_s, out_en_s, ovr_s;

   logic [WGAIN-1:0]         gain_r      [NCH];
   logic [WGAIN-1:0]         gain_snap_r [NCH];
   logic signed [WIN-1:0]    cap_l_r     [NCH];
   logic signed [WIN-1:0]    cap_r_r     [NCH];
   logic [NCH-1:0]           mute_r;
   logic [WA-1:0]            idx_r;
   logic signed [WACC-1:0]   acc_l_r, acc_r_r;

   logic signed [WOUT-1:0]   left_r, right_r;
   logic                     out_valid_r, sat_l_r, sat_r_r, busy_r, ovr_r;

   logic signed [WP-1:0]     prod_l_s, prod_r_s;
   logic signed [WACC-1:0]   term_l_s, term_r_s;
   logic signed [WACC-1:0]   sh_l_s, sh_r_s;
   logic signed [WOUT-1:0]   clamp_l_s, clamp_r_s;
   logic                     clip_l_s, clip_r_s;

   // FSM next-state and per-cycle control strobes
   always_comb begin
      state_s   = state_r;
      capture_s = 1'b0;
      acc_en_s  = 1'b0;
      out_en_s  = 1'b0;
      ovr_s     = 1'b0;
      if (mix.cen) begin
         case (state_r)
            IDLE: begin
               if (mix.sample) begin
                  capture_s = 1'b1;
                  state_s   = ACC;
               end else begin
                  state_s   = IDLE;
               end
            end
            ACC: begin
               acc_en_s = 1'b1;
               ovr_s    = mix.sample;
               if (idx_r == WA'(NCH - 1)) begin
                  state_s = OUT;
               end else begin
                  state_s = ACC;
               end
            end
            OUT: begin
               // a strobe here is dropped too: captures only happen in IDLE
               out_en_s = 1'b1;
               ovr_s    = mix.sample;
               state_s  = IDLE;
            end
            default: begin
               state_s = IDLE;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // Current channel term: muted channels contribute zero
   always_comb begin
      prod_l_s = cap_l_r[idx_r] * $signed({1'b0, gain_snap_r[idx_r]});
      prod_r_s = cap_r_r[idx_r] * $signed({1'b0, gain_snap_r[idx_r]});
      if (mute_r[idx_r]) begin
         term_l_s = {WACC{1'b0}};
         term_r_s = {WACC{1'b0}};
      end else begin
         term_l_s = WACC'(prod_l_s);
         term_r_s = WACC'(prod_r_s);
      end
   end

   // Drop the gain fraction bits and saturate both sides to WOUT
   always_comb begin
      sh_l_s = acc_l_r >>> 3'd4;
      sh_r_s = acc_r_r >>> 3'd4;
      if (sh_l_s > OUT_MAX) begin
         clamp_l_s = OUT_MAX[WOUT-1:0];
         clip_l_s  = 1'b1;
      end else if (sh_l_s < OUT_MIN) begin
         clamp_l_s = OUT_MIN[WOUT-1:0];
         clip_l_s  = 1'b1;
      end else begin
         clamp_l_s = sh_l_s[WOUT-1:0];
         clip_l_s  = 1'b0;
      end
      if (sh_r_s > OUT_MAX) begin
         clamp_r_s = OUT_MAX[WOUT-1:0];
         clip_r_s  = 1'b1;
      end else if (sh_r_s < OUT_MIN) begin
         clamp_r_s = OUT_MIN[WOUT-1:0];
         clip_r_s  = 1'b1;
      end else begin
         clamp_r_s = sh_r_s[WOUT-1:0];
         clip_r_s  = 1'b0;
      end
   end

   // Gain table: written on any clk, out-of-range addresses ignored
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < NCH; k++) gain_r[k] <= GAIN_UNITY;
      end else if (mix.gain_wr && (32'(mix.gain_addr) < NCH)) begin
         gain_r[mix.gain_addr] <= mix.gain_din;
      end
   end

   // FSM state, capture, accumulation and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         idx_r       <= {WA{1'b0}};
         acc_l_r     <= {WACC{1'b0}};
         acc_r_r     <= {WACC{1'b0}};
         mute_r      <= {NCH{1'b0}};
         for (int k = 0; k < NCH; k++) begin
            cap_l_r[k]     <= {WIN{1'b0}};
            cap_r_r[k]     <= {WIN{1'b0}};
            gain_snap_r[k] <= GAIN_UNITY;
         end
         left_r      <= {WOUT{1'b0}};
         right_r     <= {WOUT{1'b0}};
         out_valid_r <= 1'b0;
         sat_l_r     <= 1'b0;
         sat_r_r     <= 1'b0;
         busy_r      <= 1'b0;
         ovr_r       <= 1'b0;
      end else begin
         state_r     <= state_s;
         out_valid_r <= 1'b0;   // pulses clear after one clk even with cen=0
         ovr_r       <= ovr_s;
         if (capture_s) begin
            for (int k = 0; k < NCH; k++) begin
               cap_l_r[k]     <= mix.ch_l[k*WIN +: WIN];
               cap_r_r[k]     <= mix.ch_r[k*WIN +: WIN];
               gain_snap_r[k] <= gain_r[k];
            end
            mute_r  <= mix.mute;
            acc_l_r <= {WACC{1'b0}};
            acc_r_r <= {WACC{1'b0}};
            idx_r   <= {WA{1'b0}};
            busy_r  <= 1'b1;
         end
         if (acc_en_s) begin
            acc_l_r <= acc_l_r + term_l_s;
            acc_r_r <= acc_r_r + term_r_s;
            idx_r   <= idx_r + WA'(32'd1);
         end
         if (out_en_s) begin
            left_r      <= clamp_l_s;
            right_r     <= clamp_r_s;
            sat_l_r     <= clip_l_s;
            sat_r_r     <= clip_r_s;
            out_valid_r <= 1'b1;
            busy_r      <= 1'b0;
         end
      end
   end

   assign mix.left      = left_r;
   assign mix.right     = right_r;
   assign mix.out_valid = out_valid_r;
   assign mix.sat_l     = sat_l_r;
   assign mix.sat_r     = sat_r_r;
   assign mix.busy      = busy_r;
   assign mix.ovr       = ovr_r;
endmodule
